// File: rtl/i2c_target_sync.sv
// Oversampled I2C target on clk_50M: START/STOP, address match, pointer byte, burst write/read.
// Define I2C_CLK_STRETCH_EN to stretch SCL while waiting for reg_rvalid on reads.
module i2c_target_sync #(
  parameter logic [6:0] DEV_ADDR   = 7'h50,
  parameter int         NUM_REGS   = 16,
  parameter int         FILTER_LEN = 3,
  localparam int        PW         = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1
) (
  input  logic          clk_50M,
  input  logic          rst,
  input  logic          scl_in,
  input  logic          sda_in,
  output logic          sda_oe,
  output logic          scl_oe,
  output logic [PW-1:0] reg_addr,
  output logic [7:0]    reg_wdata,
  output logic          reg_we,
  output logic          reg_re,
  input  logic [7:0]    reg_rdata,
  input  logic          reg_rvalid,
  output logic          busy
);

  typedef enum logic [3:0] {
    IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WR, WR_ACK, RD_LOAD, RD, RD_MACK
  } state_t;

  state_t state, state_nxt;

  // index 1 = SCL, index 0 = SDA
  logic [1:0]      sync1, sync2, filt, filt_q;
  logic [1:0][2:0] run_cnt;

  always_ff @(posedge clk_50M or posedge rst) begin
    if (rst) begin
      sync1   <= '1;
      sync2   <= '1;
      filt    <= '1;
      filt_q  <= '1;
      run_cnt <= '0;
    end else begin
      sync1  <= {scl_in, sda_in};
      sync2  <= sync1;
      filt_q <= filt;
      for (int i = 0; i < 2; i++) begin
        if (sync2[i] == filt[i]) begin
          run_cnt[i] <= '0;
        end else if (run_cnt[i] == 3'(FILTER_LEN - 1)) begin
          filt[i]    <= sync2[i];
          run_cnt[i] <= '0;
        end else begin
          run_cnt[i] <= run_cnt[i] + 3'd1;
        end
      end
    end
  end

  logic scl_f, sda_f, scl_rise, scl_fall, sda_rise, sda_fall, start_det, stop_det;
  assign scl_f     = filt[1];
  assign sda_f     = filt[0];
  assign scl_rise  = filt[1] & ~filt_q[1];
  assign scl_fall  = ~filt[1] & filt_q[1];
  assign sda_rise  = filt[0] & ~filt_q[0];
  assign sda_fall  = ~filt[0] & filt_q[0];
  assign start_det = sda_fall & scl_f;
  assign stop_det  = sda_rise & scl_f;

  logic [7:0]    sr;
  logic [7:0]    byte_in;
  logic [2:0]    bit_cnt;
  logic [1:0]    fall_d;
  logic [PW-1:0] ptr;
  logic          rw, ack_clk, re_done, load_ok;
  logic          we_set, re_set, capture, ptr_load, ptr_inc, last_bit;

  assign byte_in  = {sr[6:0], sda_f};
  assign last_bit = (bit_cnt == 3'd7);
  assign reg_addr = ptr;

  always_ff @(posedge clk_50M or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    we_set    = 1'b0;
    re_set    = 1'b0;
    capture   = 1'b0;
    ptr_load  = 1'b0;
    ptr_inc   = 1'b0;
    if (stop_det) begin
      state_nxt = IDLE;
    end else if (start_det) begin
      state_nxt = ADDR;
    end else begin
      case (state)
        ADDR:     if (scl_rise && last_bit)
                    state_nxt = (byte_in[7:1] == DEV_ADDR) ? ADDR_ACK : IDLE;
        ADDR_ACK: if (scl_fall && ack_clk) state_nxt = rw ? RD_LOAD : PTR;
        PTR:      if (scl_rise && last_bit) begin
                    state_nxt = PTR_ACK;
                    ptr_load  = 1'b1;
                  end
        PTR_ACK:  if (scl_fall && ack_clk) state_nxt = WR;
        WR:       if (scl_rise && last_bit) begin
                    state_nxt = WR_ACK;
                    we_set    = 1'b1;
                  end
        WR_ACK:   if (scl_fall && ack_clk) begin
                    state_nxt = WR;
                    ptr_inc   = 1'b1;
                  end
        RD_LOAD:  if (!re_done) begin
                    re_set = 1'b1;
                  end else if (load_ok) begin
                    capture   = 1'b1;
                    state_nxt = RD;
                  end
        RD:       if (scl_rise && last_bit) state_nxt = RD_MACK;
        RD_MACK:  if (scl_rise) begin
                    if (sda_f) state_nxt = IDLE;
                    else       ptr_inc   = 1'b1;
                  end else if (scl_fall && ack_clk) begin
                    state_nxt = RD_LOAD;
                  end
        default:  state_nxt = state;
      endcase
    end
  end

  always_ff @(posedge clk_50M or posedge rst) begin
    if (rst) begin
      sr        <= '0;
      bit_cnt   <= '0;
      fall_d    <= '0;
      ptr       <= '0;
      rw        <= 1'b0;
      ack_clk   <= 1'b0;
      re_done   <= 1'b0;
      reg_we    <= 1'b0;
      reg_re    <= 1'b0;
      reg_wdata <= '0;
      busy      <= 1'b0;
      sda_oe    <= 1'b0;
    end else begin
      fall_d <= {fall_d[0], scl_fall};
      reg_we <= we_set;
      reg_re <= re_set;
      if (we_set) reg_wdata <= byte_in;
      if (start_det)     busy <= 1'b1;
      else if (stop_det) busy <= 1'b0;
      if (start_det || stop_det || state_nxt != state) begin
        bit_cnt <= '0;
        ack_clk <= 1'b0;
      end else if (scl_rise) begin
        bit_cnt <= bit_cnt + 3'd1;
        ack_clk <= 1'b1;
      end
      if (capture) sr <= reg_rdata;
      else if (scl_rise) begin
        case (state)
          ADDR, PTR, WR: sr <= byte_in;
          RD:            sr <= {sr[6:0], 1'b0};
          default:       sr <= sr;
        endcase
      end
      if (scl_rise && state == ADDR && last_bit) rw <= sda_f;
      if (ptr_load)     ptr <= PW'(byte_in % NUM_REGS);
      else if (ptr_inc) ptr <= (ptr == PW'(NUM_REGS - 1)) ? '0 : ptr + PW'(1);
      if (state != RD_LOAD) re_done <= 1'b0;
      else if (re_set)      re_done <= 1'b1;
      // SDA only moves two clocks after the filtered SCL fall, or when read data lands
      if (start_det || stop_det) begin
        sda_oe <= 1'b0;
      end else if (capture) begin
        sda_oe <= ~reg_rdata[7];
      end else if (fall_d[1]) begin
        case (state)
          ADDR_ACK, PTR_ACK, WR_ACK: sda_oe <= ~ack_clk;
          RD:                        sda_oe <= ~sr[7];
          default:                   sda_oe <= 1'b0;
        endcase
      end
    end
  end

`ifdef I2C_CLK_STRETCH_EN
  assign load_ok = reg_rvalid;

  always_ff @(posedge clk_50M or posedge rst) begin
    if (rst) scl_oe <= 1'b0;
    else     scl_oe <= (state == RD_LOAD);
  end
`else
  logic [1:0] ld_cnt;
  logic       unused_rvalid;

  assign unused_rvalid = reg_rvalid;
  assign scl_oe        = 1'b0;
  assign load_ok       = (ld_cnt == 2'd2);

  always_ff @(posedge clk_50M or posedge rst) begin
    if (rst)                  ld_cnt <= '0;
    else if (!re_done)        ld_cnt <= '0;
    else if (ld_cnt != 2'd3)  ld_cnt <= ld_cnt + 2'd1;
  end
`endif

endmodule

// File: tb/tb_i2c_target_sync.sv
// Scoreboard bench for i2c_target_sync: bit-banged master, register bank model, reference pointer/memory model.
module tb_i2c_target_sync;

  localparam int LO = 24, HI = 24, SETUP = 6;
`ifdef I2C_CLK_STRETCH_EN
  localparam int RD_LAT = 40;
`else
  localparam int RD_LAT = 0;
`endif

  logic clk_50M = 1'b0;
  logic rst = 1'b1;
  logic m_scl = 1'b1, m_sda = 1'b1;
  logic scl_line, sda_line;
  logic sda_oe, scl_oe, reg_we, reg_re, reg_rvalid, busy;
  logic [3:0] reg_addr;
  logic [7:0] reg_wdata, reg_rdata;

  always #10 clk_50M = ~clk_50M;

  assign scl_line = m_scl & ~scl_oe;
  assign sda_line = m_sda & ~sda_oe;

  i2c_target_sync dut (
    .clk_50M(clk_50M), .rst(rst), .scl_in(scl_line), .sda_in(sda_line),
    .sda_oe(sda_oe), .scl_oe(scl_oe), .reg_addr(reg_addr), .reg_wdata(reg_wdata),
    .reg_we(reg_we), .reg_re(reg_re), .reg_rdata(reg_rdata), .reg_rvalid(reg_rvalid),
    .busy(busy)
  );

  int n_checks = 0, n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] dflt(input logic [3:0] a);
    return {a, ~a} ^ 8'h5C;
  endfunction

  // external register bank
  logic [7:0] bank_mem [16];
  logic [15:0] bank_wr;
  logic bank_clr = 1'b1, pend;
  logic [3:0] pend_addr;
  int lat;

  always @(posedge clk_50M) begin
    reg_rvalid <= 1'b0;
    if (bank_clr) begin
      bank_wr   <= '0;
      pend      <= 1'b0;
      reg_rdata <= '0;
    end else begin
      if (reg_we) begin
        bank_mem[reg_addr] <= reg_wdata;
        bank_wr[reg_addr]  <= 1'b1;
      end
      if (reg_re) begin
        pend      <= 1'b1;
        lat       <= RD_LAT;
        pend_addr <= reg_addr;
      end else if (pend) begin
        if (lat == 0) begin
          reg_rdata  <= bank_wr[pend_addr] ? bank_mem[pend_addr] : dflt(pend_addr);
          reg_rvalid <= 1'b1;
          pend       <= 1'b0;
        end else begin
          lat <= lat - 1;
        end
      end
    end
  end

  // scoreboard monitor
  logic [11:0] exp_wr [$];
  logic [3:0]  exp_re [$];
  logic watch_nack = 1'b0;
  int oe_viol = 0, run = 0, max_run = 0, total_stretch = 0;

  always @(negedge clk_50M) begin
    if (!rst) begin
      if (reg_we) begin
        if (exp_wr.size() == 0) check("we_unexpected", reg_we, 0);
        else check("we_addr_data", {reg_addr, reg_wdata}, exp_wr.pop_front());
      end
      if (reg_re) begin
        if (exp_re.size() == 0) check("re_unexpected", reg_re, 0);
        else check("re_addr", reg_addr, exp_re.pop_front());
      end
      if (watch_nack && sda_oe) oe_viol++;
      if (scl_oe) begin
        run++;
        total_stretch++;
        if (run > max_run) max_run = run;
      end else begin
        run = 0;
      end
    end
  end

  // reference model
  logic [7:0] model_mem [16];
  int model_ptr = 0;

  task automatic wclk(input int n);
    repeat (n) @(negedge clk_50M);
  endtask

  task automatic wait_scl_high();
    int k = 0;
    while (scl_line !== 1'b1 && k < 3000) begin
      @(negedge clk_50M);
      k++;
    end
    if (k >= 3000) check("scl_release_timeout", scl_line, 1);
  endtask

  task automatic bit_wr(input logic b, input bit glitch);
    wclk(SETUP); m_sda = b;
    wclk(LO - SETUP); m_scl = 1'b1;
    wait_scl_high();
    if (glitch) begin
      wclk(HI / 2); m_scl = 1'b0;
      wclk(1);      m_scl = 1'b1;
      wclk(HI / 2 - 1);
    end else begin
      wclk(HI);
    end
    m_scl = 1'b0;
  endtask

  task automatic bit_rd(output logic b);
    wclk(SETUP); m_sda = 1'b1;
    wclk(LO - SETUP); m_scl = 1'b1;
    wait_scl_high();
    wclk(HI / 2); b = sda_line;
    wclk(HI / 2); m_scl = 1'b0;
  endtask

  task automatic start_c();
    if (m_scl) begin
      m_sda = 1'b0; wclk(HI); m_scl = 1'b0;
    end else begin
      wclk(SETUP); m_sda = 1'b1;
      wclk(LO - SETUP); m_scl = 1'b1;
      wclk(HI); m_sda = 1'b0;
      wclk(HI); m_scl = 1'b0;
    end
  endtask

  task automatic stop_c();
    wclk(SETUP); m_sda = 1'b0;
    wclk(LO - SETUP); m_scl = 1'b1;
    wait_scl_high();
    wclk(HI); m_sda = 1'b1;
    wclk(HI);
  endtask

  task automatic send_byte(input logic [7:0] b, output logic ack, input int glitch_bit);
    for (int i = 7; i >= 0; i--) bit_wr(b[i], i == glitch_bit);
    bit_rd(ack);
  endtask

  task automatic recv_byte(output logic [7:0] b, input logic nack);
    for (int i = 7; i >= 0; i--) bit_rd(b[i]);
    bit_wr(nack, 1'b0);
  endtask

  task automatic xfer_write(input logic [6:0] a, input logic [7:0] p, input logic [7:0] d [4],
                            input int n, input int glitch_bit);
    logic ack;
    bit match;
    match = (a == 7'h50);
    start_c();
    check("busy_after_start", busy, 1);
    send_byte({a, 1'b0}, ack, glitch_bit);
    check("addr_ack", ack, match ? 0 : 1);
    if (match) model_ptr = p % 16;
    send_byte(p, ack, -1);
    check("ptr_ack", ack, match ? 0 : 1);
    for (int i = 0; i < n; i++) begin
      if (match) begin
        exp_wr.push_back({model_ptr[3:0], d[i]});
        model_mem[model_ptr] = d[i];
        model_ptr = (model_ptr + 1) % 16;
      end
      send_byte(d[i], ack, -1);
      check("data_ack", ack, match ? 0 : 1);
    end
    stop_c();
    check("busy_after_stop", busy, 0);
  endtask

  task automatic xfer_read(input logic [7:0] p, input int n);
    logic ack;
    logic [7:0] b;
    start_c();
    send_byte(8'hA0, ack, -1);
    check("rd_addr_w_ack", ack, 0);
    send_byte(p, ack, -1);
    check("rd_ptr_ack", ack, 0);
    model_ptr = p % 16;
    start_c();
    send_byte(8'hA1, ack, -1);
    check("rd_addr_r_ack", ack, 0);
    for (int i = 0; i < n; i++) begin
      exp_re.push_back(model_ptr[3:0]);
      recv_byte(b, i == n - 1);
      check("rd_byte", b, model_mem[model_ptr]);
      if (i != n - 1) model_ptr = (model_ptr + 1) % 16;
    end
    check("sda_released_after_nack", sda_oe, 0);
    stop_c();
    check("busy_after_rd_stop", busy, 0);
  endtask

  initial begin
    logic [7:0] d [4];
    logic ack;
    logic [6:0] a;
    for (int i = 0; i < 16; i++) model_mem[i] = dflt(4'(i));

    wclk(4);
    check("reset_outputs", {sda_oe, scl_oe, reg_we, reg_re, busy, reg_addr, reg_wdata}, 0);
    bank_clr = 1'b0;
    rst = 1'b0;
    wclk(20);

    // basic write with pointer 3
    d = '{8'h5A, 8'hC3, 8'h00, 8'h00};
    xfer_write(7'h50, 8'h03, d, 2, -1);

    // preload wrap values, then read across the wrap with repeated START
    d = '{8'h11, 8'h22, 8'h00, 8'h00};
    xfer_write(7'h50, 8'h0F, d, 2, -1);
    max_run = 0;
    xfer_read(8'h0F, 2);
`ifdef I2C_CLK_STRETCH_EN
    check("stretch_window_ge40", max_run >= 40, 1);
`else
    check("no_stretch", total_stretch, 0);
`endif

    // address mismatch
    watch_nack = 1'b1;
    d = '{8'h12, 8'h34, 8'h00, 8'h00};
    xfer_write(7'h58, 8'h02, d, 2, -1);
    watch_nack = 1'b0;
    check("mismatch_no_sda_oe", oe_viol, 0);

    // glitch on SCL during an address bit
    d = '{8'h3C, 8'h00, 8'h00, 8'h00};
    xfer_write(7'h50, 8'h06, d, 1, 4);

    // abort after 4 data bits, then clean write
    start_c();
    send_byte(8'hA0, ack, -1);
    check("abort_addr_ack", ack, 0);
    send_byte(8'h05, ack, -1);
    check("abort_ptr_ack", ack, 0);
    for (int i = 0; i < 4; i++) bit_wr(1'b1, 1'b0);
    stop_c();
    check("abort_busy", busy, 0);
    d = '{8'h77, 8'h00, 8'h00, 8'h00};
    xfer_write(7'h50, 8'h01, d, 1, -1);

    // randomized traffic
    for (int k = 0; k < 8; k++) begin
      int kind = $urandom_range(0, 2);
      for (int j = 0; j < 4; j++) d[j] = 8'($urandom);
      if (kind == 0) begin
        xfer_write(7'h50, 8'($urandom_range(0, 255)), d, $urandom_range(1, 4), -1);
      end else if (kind == 1) begin
        xfer_read(8'($urandom_range(0, 255)), $urandom_range(1, 3));
      end else begin
        a = 7'($urandom_range(0, 127));
        if (a == 7'h50) a = 7'h51;
        xfer_write(a, 8'($urandom_range(0, 255)), d, 1, -1);
      end
    end

    // async reset in the middle of a read
    d = '{8'h00, 8'h00, 8'h00, 8'h00};
    xfer_write(7'h50, 8'h02, d, 1, -1);
    start_c();
    send_byte(8'hA0, ack, -1);
    send_byte(8'h02, ack, -1);
    start_c();
    exp_re.push_back(4'd2);
    send_byte(8'hA1, ack, -1);
    check("rst_rd_addr_ack", ack, 0);
    wclk(20);
    check("oe_active_before_rst", sda_oe | scl_oe, 1);
    #2 rst = 1'b1;
    #1;
    check("rst_sda_oe", sda_oe, 0);
    check("rst_scl_oe", scl_oe, 0);
    check("rst_busy", busy, 0);
    m_scl = 1'b1;
    m_sda = 1'b1;
    wclk(5);
    rst = 1'b0;
    wclk(20);

    check("wr_queue_empty", exp_wr.size(), 0);
    check("re_queue_empty", exp_re.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
